// File: rtl/ysyx_23060020_wbu.sv
// Writeback unit: arbitrates EXU/LSU results onto the regfile write port and tracks busy registers.
// Optional combinational bypass of the accepted transfer when YSYX_23060020_WB_BYPASS_EN is defined.
module ysyx_23060020_wbu #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_rdata,
  input  logic [1:0]      lsu_off,
  input  logic [1:0]      lsu_size,
  input  logic            lsu_sext,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic [NREG-1:0] sb_busy,
  output logic            rfwen,
  output logic [4:0]      w1a,
  output logic [XLEN-1:0] w1d,
  output logic            fwd_valid,
  output logic [4:0]      fwd_addr,
  output logic [XLEN-1:0] fwd_data
);

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0]      off,
                                                   input logic [1:0]      size,
                                                   input logic            sext);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0:    r = sext ? {{(XLEN-8){b[7]}}, b} : {{(XLEN-8){1'b0}}, b};
      2'd1:    r = sext ? {{(XLEN-16){h[15]}}, h} : {{(XLEN-16){1'b0}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  logic            lsu_fire_s;
  logic            exu_fire_s;
  logic            fire_s;
  logic [4:0]      sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic            wr_s;
  logic [NREG-1:0] set_s;
  logic [NREG-1:0] clr_s;
  logic [NREG-1:0] sb_next_s;
  logic [NREG-1:0] sb_r;
  logic            rfwen_r;
  logic [4:0]      w1a_r;
  logic [XLEN-1:0] w1d_r;

  // LSU has fixed priority; nothing is accepted while in reset
  assign lsu_ready  = !rst;
  assign exu_ready  = !rst && !lsu_valid;
  assign lsu_fire_s = lsu_valid && lsu_ready;
  assign exu_fire_s = exu_valid && exu_ready;

  // Select the winning transfer and build scoreboard set/clear masks
  always_comb begin
    fire_s     = 1'b0;
    sel_rd_s   = 5'd0;
    sel_data_s = '0;
    set_s      = '0;
    clr_s      = '0;
    if (lsu_fire_s) begin
      fire_s     = 1'b1;
      sel_rd_s   = lsu_rd;
      sel_data_s = load_extract(lsu_rdata, lsu_off, lsu_size, lsu_sext);
    end else if (exu_fire_s) begin
      fire_s     = 1'b1;
      sel_rd_s   = exu_rd;
      sel_data_s = exu_data;
    end else begin
      fire_s     = 1'b0;
    end
    wr_s = fire_s && (sel_rd_s != 5'd0);
    if (wr_s) begin
      clr_s[sel_rd_s] = 1'b1;
    end else begin
      clr_s = '0;
    end
    // a same-cycle issue is younger than the retiring write, so set wins
    if (iss_valid && (iss_rd != 5'd0)) begin
      set_s[iss_rd] = 1'b1;
    end else begin
      set_s = '0;
    end
    sb_next_s    = (sb_r & ~clr_s) | set_s;
    sb_next_s[0] = 1'b0;
  end

  // Registered regfile write stage and busy scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      rfwen_r <= 1'b0;
      w1a_r   <= 5'd0;
      w1d_r   <= '0;
      sb_r    <= '0;
    end else begin
      rfwen_r <= wr_s;
      sb_r    <= sb_next_s;
      if (fire_s) begin
        w1a_r <= sel_rd_s;
        w1d_r <= sel_data_s;
      end
    end
  end

  assign rfwen   = rfwen_r;
  assign w1a     = w1a_r;
  assign w1d     = w1d_r;
  assign sb_busy = sb_r;

`ifdef YSYX_23060020_WB_BYPASS_EN
  assign fwd_valid = wr_s;
  assign fwd_addr  = wr_s ? sel_rd_s : 5'd0;
  assign fwd_data  = wr_s ? sel_data_s : '0;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = 5'd0;
  assign fwd_data  = '0;
`endif

endmodule
